// File: rtl/knn_topk_engine_if.sv
// Bus bundle for knn_topk_engine: query start, search-vector stream, abort and result channel.
// Handshake rule for every channel: a beat transfers on the rising clk edge where valid and ready
// are both high; the producer holds valid and payload steady until then; ready never looks at valid.
interface knn_topk_engine_if #(
  parameter int ELEM_W  = 4,
  parameter int DIMS    = 16,
  parameter int NUM_VEC = 8,
  parameter int K       = 2
);
  localparam int IDX_W  = ($clog2(NUM_VEC) > 1) ? $clog2(NUM_VEC) : 1;
  localparam int DIST_W = 2 * ELEM_W + $clog2(DIMS);

  logic                     start_valid;
  logic                     start_ready;
  logic [ELEM_W*DIMS-1:0]   query;
  logic                     vec_valid;
  logic                     vec_ready;
  logic [ELEM_W*DIMS-1:0]   vec_data;
  logic                     clear;
  logic                     out_valid;
  logic                     out_ready;
  logic [K*IDX_W-1:0]       out_idx;
  logic [K*DIST_W-1:0]      out_dist;

  modport master (
    output start_valid, query, vec_valid, vec_data, clear, out_ready,
    input  start_ready, vec_ready, out_valid, out_idx, out_dist
  );

  modport slave (
    input  start_valid, query, vec_valid, vec_data, clear, out_ready,
    output start_ready, vec_ready, out_valid, out_idx, out_dist
  );
endinterface

// File: rtl/knn_topk_engine.sv
// Streaming K-nearest-neighbour engine keeping a sorted top-K (index, distance) list per query.
// Define KNN_L1_EN for Manhattan distance; otherwise squared Euclidean distance is used.
module knn_topk_engine #(
  parameter int ELEM_W  = 4,
  parameter int DIMS    = 16,
  parameter int NUM_VEC = 8,
  parameter int K       = 2
) (
  input  logic               clk,
  input  logic               rst,
  knn_topk_engine_if.slave   bus,
  output logic [1:0]         dbg_state
);
  localparam int IDX_W  = ($clog2(NUM_VEC) > 1) ? $clog2(NUM_VEC) : 1;
  localparam int DIST_W = 2 * ELEM_W + $clog2(DIMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  if (K < 1 || K > NUM_VEC || NUM_VEC < 2) begin : g_bad_cfg
    $error("knn_topk_engine: requires NUM_VEC >= 2 and 1 <= K <= NUM_VEC");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [ELEM_W*DIMS-1:0] query_q, query_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q, s1_last_d;
  logic [DIST_W-1:0]      s1_dist_q, s1_dist_d;
  logic [IDX_W-1:0]       s1_idx_q, s1_idx_d;
  logic                   s2_done_q, s2_done_d;
  logic [DIST_W-1:0]      dist_q [K];
  logic [DIST_W-1:0]      dist_d [K];
  logic [IDX_W-1:0]       idx_q  [K];
  logic [IDX_W-1:0]       idx_d  [K];

  // Distance of the incoming beat against the stored query; the sum cannot overflow DIST_W.
  logic [DIST_W-1:0] vec_dist;
  logic [ELEM_W-1:0] elem_q, elem_v, elem_diff;
`ifndef KNN_L1_EN
  logic [2*ELEM_W-1:0] diff_ext;
`endif

  always_comb begin
    vec_dist  = '0;
    elem_q    = '0;
    elem_v    = '0;
    elem_diff = '0;
`ifndef KNN_L1_EN
    diff_ext  = '0;
`endif
    for (int j = 0; j < DIMS; j++) begin
      elem_q    = query_q[j*ELEM_W +: ELEM_W];
      elem_v    = bus.vec_data[j*ELEM_W +: ELEM_W];
      elem_diff = (elem_q > elem_v) ? (elem_q - elem_v) : (elem_v - elem_q);
`ifdef KNN_L1_EN
      vec_dist  = vec_dist + DIST_W'(elem_diff);
`else
      diff_ext  = {{ELEM_W{1'b0}}, elem_diff};
      vec_dist  = vec_dist + DIST_W'(diff_ext * diff_ext);
`endif
    end
  end

  // Insertion compare; the list is ascending so lt[] is a run of 0s followed by 1s.
  logic [K-1:0] lt;
  always_comb begin
    lt = '0;
    for (int s = 0; s < K; s++) lt[s] = (s1_dist_q < dist_q[s]);
  end

  always_comb begin
    state_d    = state_q;
    query_d    = query_q;
    cnt_d      = cnt_q;
    s1_valid_d = 1'b0;
    s1_last_d  = s1_last_q;
    s1_dist_d  = s1_dist_q;
    s1_idx_d   = s1_idx_q;
    s2_done_d  = s2_done_q;
    dist_d     = dist_q;
    idx_d      = idx_q;

    case (state_q)
      S_IDLE: if (bus.start_valid) begin
        query_d   = bus.query;
        cnt_d     = '0;
        s2_done_d = 1'b0;
        for (int s = 0; s < K; s++) begin
          dist_d[s] = '1;
          idx_d[s]  = '0;
        end
        state_d   = S_LOAD;
      end
      S_LOAD: if (bus.vec_valid) begin
        s1_valid_d = 1'b1;
        s1_dist_d  = vec_dist;
        s1_idx_d   = cnt_q;
        s1_last_d  = (cnt_q == LAST_IDX);
        cnt_d      = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: if (s2_done_q) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stage 2: strict less-than insertion, so equal distances stay behind earlier indices.
    if (s1_valid_q) begin
      if (lt[0]) begin
        dist_d[0] = s1_dist_q;
        idx_d[0]  = s1_idx_q;
      end
      for (int s = 1; s < K; s++) begin
        if (lt[s]) begin
          dist_d[s] = lt[s-1] ? dist_q[s-1] : s1_dist_q;
          idx_d[s]  = lt[s-1] ? idx_q[s-1]  : s1_idx_q;
        end
      end
      if (s1_last_q) s2_done_d = 1'b1;
    end

    if (bus.clear) begin
      state_d    = S_IDLE;
      s1_valid_d = 1'b0;
      s2_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      query_q    <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_dist_q  <= '0;
      s1_idx_q   <= '0;
      s2_done_q  <= 1'b0;
      for (int s = 0; s < K; s++) begin
        dist_q[s] <= '0;
        idx_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      query_q    <= query_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_dist_q  <= s1_dist_d;
      s1_idx_q   <= s1_idx_d;
      s2_done_q  <= s2_done_d;
      dist_q     <= dist_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.vec_ready   = (state_q == S_LOAD);
  assign bus.out_valid   = (state_q == S_DONE);
  assign dbg_state       = state_q;

  for (genvar s = 0; s < K; s++) begin : g_pack
    assign bus.out_idx[s*IDX_W +: IDX_W]    = idx_q[s];
    assign bus.out_dist[s*DIST_W +: DIST_W] = dist_q[s];
  end
endmodule
